// File: rtl/clk_freq_meter.sv
// clk_freq_meter: counts rising edges of an asynchronous signal inside a
// fixed gate window of GATE_CYCLES board-clock cycles and publishes the
// result with a one-cycle valid strobe. Windows run back-to-back while en=1.
module clk_freq_meter #(
  parameter int GATE_CYCLES = 1000,
  parameter int CNT_W       = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             sig_in,
  output logic [CNT_W-1:0] freq_cnt,
  output logic             valid,
  output logic             ovf,
  output logic             busy
);

  // gate_cnt only has to reach GATE_CYCLES-1; keep at least one bit.
  localparam int GW = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
  localparam logic [GW-1:0]    GATE_LAST = GW'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARM   = 2'd1,
    S_GATE  = 2'd2,
    S_LATCH = 2'd3
  } state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   edge_prev;
  logic                   rise;
  logic [GW-1:0]          gate_cnt;
  logic [CNT_W-1:0]       edge_cnt;
  logic                   ovf_w;

  // Synchronizer chain plus edge-history flop for the asynchronous input.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of its neighbours, giving a true shift chain.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q    <= '0;
      edge_prev <= 1'b0;
    end else begin
      sync_q    <= {sync_q[SYNC_STAGES-2:0], sig_in};
      edge_prev <= sync_q[SYNC_STAGES-1];
    end
  end

  assign rise = sync_q[SYNC_STAGES-1] & ~edge_prev;
  assign busy = (state_q != S_IDLE);

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  // Next-state logic: IDLE -> ARM -> GATE x GATE_CYCLES -> LATCH -> ARM/IDLE.
  // NOTE: state_d gets its default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (en) state_d = S_ARM;
      S_ARM:   state_d = S_GATE;
      S_GATE: begin
        if (!en)                         state_d = S_IDLE;
        else if (gate_cnt == GATE_LAST)  state_d = S_LATCH;
      end
      S_LATCH: state_d = en ? S_ARM : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Window datapath: clear in ARM, count in GATE, publish in LATCH.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      gate_cnt <= '0;
      edge_cnt <= '0;
      ovf_w    <= 1'b0;
      freq_cnt <= '0;
      ovf      <= 1'b0;
      valid    <= 1'b0;
    end else begin
      valid <= 1'b0;
      case (state_q)
        S_ARM: begin
          gate_cnt <= '0;
          edge_cnt <= '0;
          ovf_w    <= 1'b0;
        end
        S_GATE: begin
          // An en=0 cycle aborts the window; the counters are simply
          // abandoned and re-cleared by the next ARM.
          if (en) begin
            if (gate_cnt != GATE_LAST) gate_cnt <= gate_cnt + GW'(1);
            if (rise) begin
              if (edge_cnt == CNT_MAX) ovf_w    <= 1'b1;
              else                     edge_cnt <= edge_cnt + CNT_W'(1);
            end
          end
        end
        S_LATCH: begin
          freq_cnt <= edge_cnt;
          ovf      <= ovf_w;
          valid    <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_clk_freq_meter.sv
// Self-checking bench for clk_freq_meter. Three instances with different
// gate lengths / counter widths share clk, rst and sig_in. The reference
// model records the synchronous samples of sig_in and, for each window,
// counts 0->1 transitions seen SYNC+1 cycles late over the gate cycles.
module tb_clk_freq_meter;

  localparam int SYNC = 2;
  localparam int HMAX = 16384;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic sig_in = 1'b0;
  logic en_a = 1'b0, en_b = 1'b0, en_c = 1'b0;

  logic [31:0] freq_a;
  logic [3:0]  freq_b;
  logic [7:0]  freq_c;
  logic valid_a, valid_b, valid_c;
  logic ovf_a, ovf_b, ovf_c;
  logic busy_a, busy_b, busy_c;

  clk_freq_meter #(.GATE_CYCLES(100), .CNT_W(32), .SYNC_STAGES(SYNC)) dut_a (
    .clk(clk), .rst(rst), .en(en_a), .sig_in(sig_in),
    .freq_cnt(freq_a), .valid(valid_a), .ovf(ovf_a), .busy(busy_a));

  clk_freq_meter #(.GATE_CYCLES(100), .CNT_W(4), .SYNC_STAGES(SYNC)) dut_b (
    .clk(clk), .rst(rst), .en(en_b), .sig_in(sig_in),
    .freq_cnt(freq_b), .valid(valid_b), .ovf(ovf_b), .busy(busy_b));

  clk_freq_meter #(.GATE_CYCLES(1), .CNT_W(8), .SYNC_STAGES(SYNC)) dut_c (
    .clk(clk), .rst(rst), .en(en_c), .sig_in(sig_in),
    .freq_cnt(freq_c), .valid(valid_c), .ovf(ovf_c), .busy(busy_c));

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Sample history: hist[n] is the input level seen at posedge n
  // (forced low while reset holds the synchronizer clear).
  int unsigned cyc = 0;
  bit hist [HMAX];

  always @(posedge clk) begin
    if (cyc < HMAX) hist[cyc] = rst & sig_in;
    cyc++;
  end

  // Stimulus generator: 0 = hold low, 1 = square wave of gen_per,
  // 2 = random level lengths of 2..7 cycles.
  int gen_mode = 0;
  int gen_per  = 4;
  int gen_left = 0;

  initial forever begin
    @(negedge clk);
    case (gen_mode)
      0: sig_in = 1'b0;
      1: begin
        if (gen_left <= 1) begin sig_in = ~sig_in; gen_left = gen_per / 2; end
        else gen_left--;
      end
      default: begin
        if (gen_left <= 1) begin sig_in = ~sig_in; gen_left = int'($urandom_range(2, 7)); end
        else gen_left--;
      end
    endcase
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic bit h(input int i);
    if (i < 0 || i >= HMAX) return 1'b0;
    return hist[i];
  endfunction

  // Count rising edges over the gate cycles [first, first+g-1], then saturate.
  function automatic void model(input int first, input int g, input int cw,
                                output longint cnt, output bit ov);
    longint raw = 0;
    longint mx  = (longint'(1) << cw) - 1;
    for (int j = first; j < first + g; j++)
      if (h(j - SYNC) && !h(j - SYNC - 1)) raw++;
    ov  = (raw > mx);
    cnt = ov ? mx : raw;
  endfunction

  function automatic int gate_of(input int w);
    return (w == 2) ? 1 : 100;
  endfunction

  function automatic int cw_of(input int w);
    case (w) 0: return 32; 1: return 4; default: return 8; endcase
  endfunction

  function automatic logic [63:0] f_freq(input int w);
    case (w) 0: return 64'(freq_a); 1: return 64'(freq_b); default: return 64'(freq_c); endcase
  endfunction
  function automatic logic [63:0] f_valid(input int w);
    case (w) 0: return 64'(valid_a); 1: return 64'(valid_b); default: return 64'(valid_c); endcase
  endfunction
  function automatic logic [63:0] f_ovf(input int w);
    case (w) 0: return 64'(ovf_a); 1: return 64'(ovf_b); default: return 64'(ovf_c); endcase
  endfunction
  function automatic logic [63:0] f_busy(input int w);
    case (w) 0: return 64'(busy_a); 1: return 64'(busy_b); default: return 64'(busy_c); endcase
  endfunction

  task automatic set_en(input int w, input logic v);
    case (w) 0: en_a = v; 1: en_b = v; default: en_c = v; endcase
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Enable instance w at the current negedge and follow nwin windows. Valid
  // is expected exactly GATE+2 edges after enable, then every GATE+2. Unless
  // keep_en, en is dropped during the last LATCH cycle so the run ends in IDLE.
  task automatic run_windows(input int w, input int nwin, input bit keep_en,
                             output longint last_cnt, output bit last_ovf);
    int g, e0, v, n;
    longint ec;
    bit eo;
    bool_last: begin end
    g = gate_of(w);
    last_cnt = 0;
    last_ovf = 1'b0;
    set_en(w, 1'b1);
    e0 = int'(cyc);
    for (int k = 0; k < nwin; k++) begin
      v = e0 + g + 2 + k * (g + 2);
      while (int'(cyc) < v + 1) begin
        @(negedge clk);
        n = int'(cyc) - 1;
        check("busy", f_busy(w), 64'((n == v && !keep_en && k == nwin - 1) ? 0 : 1));
        check("valid", f_valid(w), 64'(n == v));
        if (n == v) begin
          model(v - g, g, cw_of(w), ec, eo);
          check("freq_cnt", f_freq(w), 64'(ec));
          check("ovf", f_ovf(w), 64'(eo));
          last_cnt = ec;
          last_ovf = eo;
        end
        if (int'(cyc) == v && k == nwin - 1 && !keep_en) set_en(w, 1'b0);
      end
    end
  endtask

  longint exp_cnt [3];
  bit     exp_ovf [3];
  longint c;
  bit     o;
  int     w;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 3; i++) begin exp_cnt[i] = 0; exp_ovf[i] = 1'b0; end
    repeat (3) @(negedge clk);

    // Reset state of every instance.
    for (int i = 0; i < 3; i++) begin
      check("rst_freq", f_freq(i), 64'd0);
      check("rst_valid", f_valid(i), 64'd0);
      check("rst_ovf", f_ovf(i), 64'd0);
      check("rst_busy", f_busy(i), 64'd0);
    end

    // Period-4 input, en high from reset release.
    rst = 1'b1;
    gen_mode = 1; gen_per = 4;
    run_windows(0, 3, 1'b0, exp_cnt[0], exp_ovf[0]);
    check("t1_count_25", (exp_cnt[0] >= 24 && exp_cnt[0] <= 26) ? 64'd1 : 64'd0, 64'd1);
    idle(5);
    check("hold_idle_freq", f_freq(0), 64'(exp_cnt[0]));
    check("hold_idle_busy", f_busy(0), 64'd0);

    // Input held low: zero count, valid still pulses.
    gen_mode = 0;
    idle(3);
    run_windows(0, 2, 1'b0, exp_cnt[0], exp_ovf[0]);
    check("t2_zero", 64'(exp_cnt[0]), 64'd0);

    // Narrow counter saturates, then recovers at a low rate.
    gen_mode = 1; gen_per = 4;
    run_windows(1, 2, 1'b0, exp_cnt[1], exp_ovf[1]);
    check("t3_sat", 64'(exp_cnt[1]), 64'd15);
    gen_per = 40;
    run_windows(1, 2, 1'b0, exp_cnt[1], exp_ovf[1]);

    // One-cycle gate: valid every 3 cycles, busy never drops.
    gen_per = 8;
    run_windows(2, 6, 1'b0, exp_cnt[2], exp_ovf[2]);

    // Randomized rates, modes and instances.
    for (int r = 0; r < 8; r++) begin
      gen_mode = int'($urandom_range(1, 2));
      gen_per  = 2 * int'($urandom_range(2, 20));
      w = int'($urandom_range(0, 2));
      run_windows(w, int'($urandom_range(1, 3)), 1'b0, exp_cnt[w], exp_ovf[w]);
      idle(int'($urandom_range(1, 4)));
    end
    for (int i = 0; i < 3; i++) begin
      check("hold_freq", f_freq(i), 64'(exp_cnt[i]));
      check("hold_ovf", f_ovf(i), 64'(exp_ovf[i]));
    end

    // en dropped 50 cycles into a window: abort, no valid, result held.
    gen_mode = 1; gen_per = 4;
    run_windows(0, 1, 1'b1, exp_cnt[0], exp_ovf[0]);
    idle(51);
    en_a = 1'b0;
    @(negedge clk);
    check("abort_busy", f_busy(0), 64'd0);
    for (int i = 0; i < 105; i++) begin
      check("abort_valid", f_valid(0), 64'd0);
      @(negedge clk);
    end
    check("abort_freq", f_freq(0), 64'(exp_cnt[0]));
    check("abort_ovf", f_ovf(0), 64'(exp_ovf[0]));

    // Reset pulse 30 cycles into GATE clears everything immediately.
    en_a = 1'b1;
    idle(32);
    #2 rst = 1'b0;
    #1;
    check("async_busy", f_busy(0), 64'd0);
    check("async_freq", f_freq(0), 64'd0);
    check("async_valid", f_valid(0), 64'd0);
    for (int i = 1; i < 3; i++) begin exp_cnt[i] = 0; exp_ovf[i] = 1'b0; end
    @(negedge clk);
    rst = 1'b1;
    run_windows(0, 1, 1'b0, exp_cnt[0], exp_ovf[0]);
    for (int i = 1; i < 3; i++) begin
      check("post_rst_freq", f_freq(i), 64'(exp_cnt[i]));
      check("post_rst_busy", f_busy(i), 64'd0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
